// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: opcodes, instruction
// field positions and the fetch state encoding.
package fetch_unit_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] instr_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_pc_calc.sv
// Fetch address selection: sequential PC, absolute target from the
// instruction, or CUR_PC plus the sign-extended 16-bit immediate.
module fetch_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_cur_pc,
    input  logic [31:0]       i_instr,
    input  logic              i_pc_sel,
    input  logic              i_br_sel,
    output logic [ADDR_W-1:0] o_addr
);

    logic [31:0] w_rel_full;
    logic        w_unused;

    // Sum is formed at 32 bits and truncated, giving the mod 2^ADDR_W wrap.
    assign w_rel_full = 32'(i_cur_pc) + 32'($signed(i_instr[IMM_MSB:IMM_LSB]));
    assign w_unused   = &{1'b0, w_rel_full, i_instr};

    always_comb begin
        o_addr = i_pc;
        if (i_pc_sel) begin
            if (i_br_sel) begin
                o_addr = i_instr[ADDR_W-1:0];
            end else begin
                o_addr = w_rel_full[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC/IR ownership and IMEM request/acknowledge.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_RST,
    input  logic              PC_WRITE,
    input  logic              PC_SEL,
    input  logic              BR_SEL,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [31:0]       IMEM_RDATA,
    output logic [31:0]       INSTR,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [ADDR_W-1:0] PC,
    output logic              INSTR_VALID,
    output logic              BUSY,
    output logic              HALTED,
    output logic              FETCH_ERR
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_cur_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_err;
    logic [ADDR_W-1:0] w_target;
    logic              w_launch;
    logic              w_accept;
    logic              w_timeout;
    logic              w_expired;

    fetch_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_calc (
        .i_pc     (r_pc),
        .i_cur_pc (r_cur_pc),
        .i_instr  (r_instr),
        .i_pc_sel (PC_SEL),
        .i_br_sel (BR_SEL),
        .o_addr   (w_target)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Counts completed REQ cycles; cleared whenever REQ is entered or left.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_REQ || w_state_next != ST_REQ) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC_RST outranks everything, including an ACK in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        if (PC_RST) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PC_WRITE) begin
                        w_launch     = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IMEM_ACK) begin
                        w_accept     = 1'b1;
                        w_state_next = (instr_opcode(IMEM_RDATA) == OP_HLT) ? ST_HALT : ST_IDLE;
                    end else if (w_expired) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc     <= RESET_VEC;
            r_cur_pc <= RESET_VEC;
            r_addr   <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (PC_RST) begin
                r_pc     <= RESET_VEC;
                r_cur_pc <= RESET_VEC;
                r_instr  <= '0;
                r_err    <= 1'b0;
            end else if (w_launch) begin
                r_addr <= w_target;
            end else if (w_accept) begin
                r_instr  <= IMEM_RDATA;
                r_cur_pc <= r_addr;
                r_pc     <= r_addr + ADDR_W'(1);
                r_valid  <= 1'b1;
            end else if (w_timeout) begin
                r_instr <= '0;
                r_err   <= 1'b1;
                r_valid <= 1'b1;
            end
        end
    end

    assign IMEM_REQ    = (r_state == ST_REQ);
    assign BUSY        = (r_state == ST_REQ);
    assign HALTED      = (r_state == ST_HALT);
    assign IMEM_ADDR   = r_addr;
    assign INSTR       = r_instr;
    assign OPCODE      = r_instr[OPC_MSB:OPC_LSB];
    assign MM          = r_instr[MM_MSB:MM_LSB];
    assign PC          = r_pc;
    assign INSTR_VALID = r_valid;
    assign FETCH_ERR   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a high-level
// model of PC, CUR_PC, INSTR and the halt condition.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_RST = 1'b0;
  logic        PC_WRITE = 1'b0;
  logic        PC_SEL = 1'b0;
  logic        BR_SEL = 1'b0;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic [31:0] INSTR;
  logic [3:0]  OPCODE;
  logic [3:0]  MM;
  logic [15:0] PC;
  logic        INSTR_VALID;
  logic        BUSY;
  logic        HALTED;
  logic        FETCH_ERR;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_cur = 16'h0;
  logic [31:0] m_instr = 32'h0;
  bit          m_halted = 1'b0;
  bit          m_err = 1'b0;

  fetch_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC_RST      (PC_RST),
    .PC_WRITE    (PC_WRITE),
    .PC_SEL      (PC_SEL),
    .BR_SEL      (BR_SEL),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_ACK    (IMEM_ACK),
    .IMEM_RDATA  (IMEM_RDATA),
    .INSTR       (INSTR),
    .OPCODE      (OPCODE),
    .MM          (MM),
    .PC          (PC),
    .INSTR_VALID (INSTR_VALID),
    .BUSY        (BUSY),
    .HALTED      (HALTED),
    .FETCH_ERR   (FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_target(input bit sel, input bit br);
    int t;
    if (!sel) return m_pc;
    if (br) return m_instr[15:0];
    t = int'(m_cur) + int'($signed(m_instr[15:0]));
    t = (t + 65536) % 65536;
    return 16'(t);
  endfunction

  task automatic check_arch(input string tag);
    check({tag, ".instr"}, INSTR, m_instr);
    check({tag, ".opcode"}, 32'(OPCODE), 32'(m_instr[31:28]));
    check({tag, ".mm"}, 32'(MM), 32'(m_instr[27:24]));
    check({tag, ".pc"}, 32'(PC), 32'(m_pc));
    check({tag, ".halted"}, 32'(HALTED), 32'(m_halted));
    check({tag, ".err"}, 32'(FETCH_ERR), 32'(m_err));
  endtask

  // One complete fetch: request, 'waits' memory wait states, then ACK.
  task automatic fetch(input string tag, input bit sel, input bit br, input int waits,
                       input logic [31:0] word, input bit poke);
    logic [15:0] a;
    int t;
    a = ref_target(sel, br);
    @(negedge CLK);
    PC_WRITE = 1'b1; PC_SEL = sel; BR_SEL = br;
    @(negedge CLK);
    PC_WRITE = 1'b0; PC_SEL = 1'($urandom); BR_SEL = 1'($urandom);
    check({tag, ".req"}, 32'(IMEM_REQ), 32'd1);
    check({tag, ".addr"}, 32'(IMEM_ADDR), 32'(a));
    check({tag, ".busy"}, 32'(BUSY), 32'd1);
    check({tag, ".valid_early"}, 32'(INSTR_VALID), 32'd0);
    for (int i = 0; i < waits; i++) begin
      PC_WRITE = poke && (i == 0);
      @(negedge CLK);
      PC_WRITE = 1'b0;
      check({tag, ".req_hold"}, 32'(IMEM_REQ), 32'd1);
      check({tag, ".addr_hold"}, 32'(IMEM_ADDR), 32'(a));
      check({tag, ".valid_wait"}, 32'(INSTR_VALID), 32'd0);
    end
    IMEM_ACK = 1'b1; IMEM_RDATA = word;
    @(negedge CLK);
    IMEM_ACK = 1'b0; IMEM_RDATA = $urandom;
    m_instr = word;
    m_cur = a;
    t = (int'(a) + 1) % 65536;
    m_pc = 16'(t);
    m_halted = (word[31:28] == 4'd15);
    check({tag, ".valid"}, 32'(INSTR_VALID), 32'd1);
    check({tag, ".req_drop"}, 32'(IMEM_REQ), 32'd0);
    check_arch(tag);
    @(negedge CLK);
    check({tag, ".valid_pulse"}, 32'(INSTR_VALID), 32'd0);
    check({tag, ".no_rereq"}, 32'(IMEM_REQ), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    return {4'($urandom_range(0, 14)), 28'($urandom)};
  endfunction

  initial begin
    logic [15:0] hold_pc;
    // Reset
    repeat (3) @(negedge CLK);
    check("rst.req", 32'(IMEM_REQ), 32'd0);
    check("rst.addr", 32'(IMEM_ADDR), 32'd0);
    check("rst.valid", 32'(INSTR_VALID), 32'd0);
    check("rst.busy", 32'(BUSY), 32'd0);
    check_arch("rst");
    RST = 1'b0;
    @(negedge CLK);

    // Zero-wait sequential fetch from reset vector
    fetch("seq0", 1'b0, 1'b0, 0, 32'h8100_0003, 1'b0);
    check("seq0.opc8", 32'(OPCODE), 32'd8);
    check("seq0.pc1", 32'(PC), 32'd1);

    // Absolute branch to 0x10, then relative -4 and absolute 0x40
    fetch("seq1", 1'b0, 1'b0, 0, 32'h4000_0010, 1'b0);
    fetch("abs10", 1'b1, 1'b1, 1, 32'h5000_FFFC, 1'b0);
    fetch("relm4", 1'b1, 1'b0, 0, 32'h4000_0040, 1'b0);
    check("relm4.cur", 32'(m_cur), 32'h000C);
    fetch("abs40", 1'b1, 1'b1, 0, rand_word(), 1'b0);
    check("abs40.pc", 32'(PC), 32'h0041);

    // Three wait states with PC_WRITE pulsed during REQ
    fetch("wait3", 1'b0, 1'b0, 3, rand_word(), 1'b1);

    // Wrap at 0xFFFF and relative branch across zero
    fetch("w0", 1'b0, 1'b0, 0, 32'h4000_FFFF, 1'b0);
    fetch("wffff", 1'b1, 1'b1, 0, 32'h4000_FFFE, 1'b0);
    check("wffff.pc0", 32'(PC), 32'h0000);
    fetch("wfffe", 1'b1, 1'b1, 2, 32'h5000_0004, 1'b0);
    fetch("relp4", 1'b1, 1'b0, 0, rand_word(), 1'b0);
    check("relp4.cur", 32'(m_cur), 32'h0002);

    // Randomized fetches
    for (int i = 0; i < 40; i++) begin
      fetch("rand", 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            rand_word(), 1'($urandom));
    end

    // Halt, ignored requests, then PC_RST
    fetch("hlt", 1'b0, 1'b0, 1, 32'hF000_0000, 1'b0);
    hold_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      PC_WRITE = 1'b1;
      @(negedge CLK);
      PC_WRITE = 1'b0;
      check("hlt.no_req", 32'(IMEM_REQ), 32'd0);
      check("hlt.stay", 32'(HALTED), 32'd1);
      check("hlt.pc", 32'(PC), 32'(hold_pc));
    end
    PC_RST = 1'b1;
    @(negedge CLK);
    PC_RST = 1'b0;
    m_pc = 16'h0; m_cur = 16'h0; m_instr = 32'h0; m_halted = 1'b0; m_err = 1'b0;
    check_arch("pcrst_hlt");
    check("pcrst_hlt.busy", 32'(BUSY), 32'd0);
    fetch("after_hlt", 1'b0, 1'b0, 0, rand_word(), 1'b0);

    // PC_RST mid-REQ with a coincident and a late ACK
    @(negedge CLK);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    @(negedge CLK);
    PC_WRITE = 1'b0;
    check("abort.req", 32'(IMEM_REQ), 32'd1);
    @(negedge CLK);
    PC_RST = 1'b1; IMEM_ACK = 1'b1; IMEM_RDATA = 32'h8123_4567;
    @(negedge CLK);
    PC_RST = 1'b0;
    m_pc = 16'h0; m_cur = 16'h0; m_instr = 32'h0; m_halted = 1'b0; m_err = 1'b0;
    check("abort.req_drop", 32'(IMEM_REQ), 32'd0);
    check("abort.valid", 32'(INSTR_VALID), 32'd0);
    check_arch("abort");
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    check("late_ack.valid", 32'(INSTR_VALID), 32'd0);
    check("late_ack.req", 32'(IMEM_REQ), 32'd0);
    check_arch("late_ack");

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: abort after 15 REQ cycles
    fetch("pre_to", 1'b0, 1'b0, 0, rand_word(), 1'b0);
    @(negedge CLK);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    @(negedge CLK);
    PC_WRITE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to.req", 32'(IMEM_REQ), 32'd1);
      check("to.valid_wait", 32'(INSTR_VALID), 32'd0);
      @(negedge CLK);
    end
    m_instr = 32'h0; m_err = 1'b1;
    check("to.req_drop", 32'(IMEM_REQ), 32'd0);
    check("to.valid", 32'(INSTR_VALID), 32'd1);
    check_arch("to");
    @(negedge CLK);
    check("to.sticky", 32'(FETCH_ERR), 32'd1);
    PC_RST = 1'b1;
    @(negedge CLK);
    PC_RST = 1'b0;
    m_pc = 16'h0; m_cur = 16'h0; m_instr = 32'h0; m_halted = 1'b0; m_err = 1'b0;
    check_arch("to_clr");
`endif

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch side of the multicycle core: owns the program counter and instruction register, and consumes the PC-control signals issued by the control FSM (PC_RST, PC_WRITE, PC_SEL, BR_SEL). It runs a request/acknowledge handshake with instruction memory, computes sequential and branch addresses, and returns the latched instruction plus its OPCODE/MM fields to the controller.

## Interface
- ADDR_W, 16, instruction address width (word addressed)
- RESET_VEC, 0, PC value after RST or PC_RST
- TIMEOUT_CYC, 15, max wait cycles for IMEM_ACK (used only with FETCH_TIMEOUT_EN)
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- PC_RST  in  1  synchronous PC reset / fetch abort
- PC_WRITE  in  1  fetch request, one-cycle pulse
- PC_SEL  in  1  0 = sequential, 1 = branch target
- BR_SEL  in  1  0 = relative, 1 = absolute (valid when PC_SEL=1)
- IMEM_REQ  out  1  memory read request
- IMEM_ADDR  out  ADDR_W  read address, held while IMEM_REQ=1
- IMEM_ACK  in  1  read data valid
- IMEM_RDATA  in  32  instruction word
- INSTR  out  32  instruction register
- OPCODE  out  4  INSTR[31:28]
- MM  out  4  INSTR[27:24]
- PC  out  ADDR_W  address of next sequential fetch
- INSTR_VALID  out  1  one-cycle pulse after a new instruction is latched
- BUSY  out  1  high in REQ state
- HALTED  out  1  high in HALT state
- FETCH_ERR  out  1  sticky timeout flag (0 when FETCH_TIMEOUT_EN is undefined)

## Operation
- States: IDLE, REQ, HALT.
- IDLE + PC_WRITE: fetch address A = PC if PC_SEL=0; A = INSTR[ADDR_W-1:0] if PC_SEL=1, BR_SEL=1; A = CUR_PC + sext(INSTR[15:0]) mod 2^ADDR_W if PC_SEL=1, BR_SEL=0. CUR_PC is the address of the instruction in INSTR. IMEM_ADDR <= A; go to REQ.
- REQ: IMEM_REQ=1. On IMEM_ACK: INSTR <= IMEM_RDATA, CUR_PC <= A, PC <= A+1 (wraps at 2^ADDR_W), INSTR_VALID=1 next cycle. Next state is HALT if IMEM_RDATA[31:28]=15 (HLT), otherwise IDLE.
- PC_WRITE in REQ or HALT: ignored.
- HALT: all fetch requests ignored. Leaves only on RST or PC_RST.
- PC_RST (any state, priority over PC_WRITE/ACK): PC <= RESET_VEC, INSTR <= 0 (NOOP), CUR_PC <= RESET_VEC, IMEM_REQ drops the next edge, state <= IDLE, FETCH_ERR cleared. An ACK arriving in the same cycle is discarded.
- RST: every output 0, except PC = RESET_VEC; state IDLE.

## Timing
- PC_WRITE sampled at edge n; IMEM_REQ/IMEM_ADDR valid from n+1.
- IMEM_ACK may be high in the first REQ cycle (zero-wait). INSTR, OPCODE, MM and PC update at the edge where REQ&ACK=1. INSTR_VALID is high for exactly the following cycle.
- Minimum latency: PC_WRITE edge to INSTR_VALID high = 2 cycles; each memory wait state adds 1.
- IMEM_ADDR is stable and IMEM_REQ stays high until ACK or abort; no new request in the cycle following ACK.
- OPCODE/MM are pure slices of INSTR, with no extra delay.

## Configuration
- FETCH_TIMEOUT_EN defined: a wait counter runs in REQ. After TIMEOUT_CYC cycles with no ACK: request aborted, INSTR <= 0 (NOOP), PC unchanged, FETCH_ERR <= 1 (sticky until RST/PC_RST), INSTR_VALID pulses, state IDLE.
- Undefined: no counter; REQ waits indefinitely; FETCH_ERR tied 0.

## Structure
- Shared package: opcode constants (NOOP 0, LOD 1, STR 2, BRA 4, BRR 5, BNE 6, ALU 8, HLT 15), instruction field positions (opcode 31:28, MM 27:24, immediate 15:0), fetch state encoding.
- One combinational sub-module, fetch_pc_calc: computes A from PC, CUR_PC, INSTR, PC_SEL and BR_SEL.

## Test plan
- RST, then PC_WRITE (PC_SEL=0) with zero-wait memory returning 0x8100_0003 -> IMEM_ADDR=0, INSTR_VALID 2 cycles after the PC_WRITE edge, OPCODE=8, MM=1, PC=1.
- Branch at CUR_PC=0x0010, INSTR[15:0]=0xFFFC, PC_SEL=1, BR_SEL=0 -> IMEM_ADDR=0x000C; with BR_SEL=1 and INSTR[15:0]=0x0040 -> IMEM_ADDR=0x0040.
- Memory with 3 wait states; PC_WRITE pulsed again during REQ -> single request only, IMEM_ADDR held, INSTR_VALID 5 cycles after the first PC_WRITE edge.
- Fetch at PC=0xFFFF -> PC wraps to 0x0000; relative branch from 0xFFFE with offset +4 -> IMEM_ADDR=0x0002.
- Fetched word 0xF000_0000 -> HALTED=1, further PC_WRITE produces no IMEM_REQ; PC_RST -> IDLE, PC=RESET_VEC, INSTR=0.
- FETCH_TIMEOUT_EN with ACK never asserted -> after 15 REQ cycles: IMEM_REQ=0, FETCH_ERR=1, INSTR=0, PC unchanged. PC_RST asserted mid-REQ -> request dropped the next edge, late ACK ignored.
